fb_row_writer: RTL and testbench

Frame-buffer write-side endpoint for the RGB panel pipeline. It consumes the row-oriented write interface that pattern generators drive (column writes into a line buffer, then row store/swap, then frame swap). It copies each completed row into a double-banked frame memory and exposes the displayed bank to the panel scanner. It owns the `fbw_row_rdy` and `frame_rdy` handshakes, and the bank flip is synchronised to the scanner's frame boundary.

---
 rtl/fb_row_writer.sv | 137 +++++++++++++
 tb/tb_fb_row_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_row_writer.sv
// Frame-buffer write endpoint: it copies line-buffer rows into a double-banked frame memory and flips the displayed bank.
// Optional macro FB_ROW_WRITER_VSYNC_SWAP_EN gates the bank flip on disp_vsync. When undefined, the flip happens as soon as it is legal.
module fb_row_writer #(
    parameter int N_ROWS     = 64,
    parameter int N_COLS     = 64,
    parameter int LOG_N_ROWS = $clog2(N_ROWS),
    parameter int LOG_N_COLS = $clog2(N_COLS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [23:0]                           fbw_data,
    input  logic [LOG_N_COLS-1:0]                 fbw_col_addr,
    input  logic                                  fbw_wren,
    input  logic [LOG_N_ROWS-1:0]                 fbw_row_addr,
    input  logic                                  fbw_row_store,
    input  logic                                  fbw_row_swap,
    output logic                                  fbw_row_rdy,
    input  logic                                  frame_swap,
    output logic                                  frame_rdy,
    output logic [LOG_N_ROWS+LOG_N_COLS:0]        mem_addr,
    output logic [23:0]                           mem_data,
    output logic                                  mem_we,
    input  logic                                  disp_vsync,
    output logic                                  disp_bank
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COPY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [LOG_N_COLS-1:0] LAST_COL = LOG_N_COLS'(N_COLS - 1);

    logic [1:0]            state;
    logic                  wr_sel;
    logic                  swap_pend;
    logic                  src_sel;
    logic                  dst_bank;
    logic [LOG_N_ROWS-1:0] dst_row;
    logic [LOG_N_COLS-1:0] rd_col_p0;
    logic                  vld_p0;
    logic                  store_ok;
    logic                  vsync_ok;
    logic                  flip_ok;
    logic [23:0]           line_buf [2][N_COLS];

    assign store_ok    = fbw_row_store && (state == ST_IDLE);
    assign vld_p0      = (state == ST_COPY);
    assign fbw_row_rdy = (state == ST_IDLE);
    assign frame_rdy   = !swap_pend && (state == ST_IDLE) && !frame_swap;

`ifdef FB_ROW_WRITER_VSYNC_SWAP_EN
    assign vsync_ok = disp_vsync;
`else
    logic unused_vsync;
    assign unused_vsync = disp_vsync;
    assign vsync_ok     = 1'b1;
`endif

    assign flip_ok = swap_pend && (state == ST_IDLE) && vsync_ok;

    // Writer side: a write in the swap cycle still lands in the old half.
    always_ff @(posedge clk) begin
        if (fbw_wren) begin
            line_buf[wr_sel][fbw_col_addr] <= fbw_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
        end else if (fbw_row_swap) begin
            wr_sel <= ~wr_sel;
        end
    end

    // Copy context is captured only when a store is accepted.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            src_sel  <= wr_sel;
            dst_bank <= ~disp_bank;
            dst_row  <= fbw_row_addr;
        end
    end

    // Stage p0: copy FSM issues one line-buffer read per COPY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_col_p0 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_col_p0 <= '0;
                    if (fbw_row_store) begin
                        state <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    rd_col_p0 <= rd_col_p0 + 1'b1;
                    if (rd_col_p0 == LAST_COL) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1: registered frame-memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= vld_p0;
            if (vld_p0) begin
                mem_addr <= {dst_bank, dst_row, rd_col_p0};
                mem_data <= line_buf[src_sel][rd_col_p0];
            end
        end
    end

    // A frame_swap that arrives while already pending is absorbed into the same flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_pend <= 1'b0;
            disp_bank <= 1'b0;
        end else if (flip_ok) begin
            swap_pend <= 1'b0;
            disp_bank <= ~disp_bank;
        end else if (frame_swap) begin
            swap_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_row_writer.sv
// Directed bench for fb_row_writer (N_ROWS=4, N_COLS=4); adapts to FB_ROW_WRITER_VSYNC_SWAP_EN.
module tb_fb_row_writer;

    logic        clk;
    logic        rst_n;
    logic [23:0] fbw_data;
    logic [1:0]  fbw_col_addr;
    logic        fbw_wren;
    logic [1:0]  fbw_row_addr;
    logic        fbw_row_store;
    logic        fbw_row_swap;
    logic        fbw_row_rdy;
    logic        frame_swap;
    logic        frame_rdy;
    logic [4:0]  mem_addr;
    logic [23:0] mem_data;
    logic        mem_we;
    logic        disp_vsync;
    logic        disp_bank;

    int total = 0;
    int bad   = 0;

    fb_row_writer #(.N_ROWS(4), .N_COLS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fbw_data(fbw_data), .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
        .fbw_row_addr(fbw_row_addr), .fbw_row_store(fbw_row_store), .fbw_row_swap(fbw_row_swap),
        .fbw_row_rdy(fbw_row_rdy), .frame_swap(frame_swap), .frame_rdy(frame_rdy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .disp_vsync(disp_vsync), .disp_bank(disp_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        fbw_wren      = 1'b0;
        fbw_row_store = 1'b0;
        fbw_row_swap  = 1'b0;
        frame_swap    = 1'b0;
        disp_vsync    = 1'b0;
    endtask

    // Called right after the store edge; mode 1 writes half 1, mode 2 issues a busy store, mode 3 issues frame swaps.
    task automatic run_copy(input int base, input int dbase, input int mode, input logic bank_old);
        int  we_cnt    = 0;
        int  low_cnt   = 0;
        bit  seen_idle = 0;
        for (int i = 0; i < 9; i++) begin
            if (!fbw_row_rdy) low_cnt++;
            if (mem_we) begin
                chk("copy_addr", 32'(mem_addr), base + we_cnt);
                chk("copy_data", 32'(mem_data), dbase + we_cnt);
                we_cnt++;
            end
            if (mode == 3 && !fbw_row_rdy) chk("bank_hold_busy", 32'(disp_bank), 32'(bank_old));
            if (mode == 3 && fbw_row_rdy && !seen_idle) begin
                seen_idle = 1;
                chk("bank_first_idle", 32'(disp_bank), 32'(bank_old));
                chk("frame_rdy_pending", 32'(frame_rdy), 0);
            end
            fbw_wren      = (mode == 1 && i < 4);
            fbw_col_addr  = i[1:0];
            fbw_data      = 24'hAA0000 | 24'(i);
            fbw_row_store = (mode == 2 && i == 2);
            fbw_row_addr  = 2'd1;
            frame_swap    = (mode == 3 && (i == 1 || i == 2));
            disp_vsync    = (mode == 3 && i == 3);
            tick();
        end
        clear_inputs();
        chk("we_count", 32'(we_cnt), 4);
        chk("rdy_low_cycles", 32'(low_cnt), 5);
    endtask

    initial begin
        rst_n        = 1'b0;
        fbw_data     = '0;
        fbw_col_addr = '0;
        fbw_row_addr = '0;
        clear_inputs();
        tick();
        tick();
        chk("rst_row_rdy", 32'(fbw_row_rdy), 1);
        chk("rst_frame_rdy", 32'(frame_rdy), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_disp_bank", 32'(disp_bank), 0);
        rst_n = 1'b1;
        tick();

        // Row 2 from half 0 into bank 1: addresses {1,2,k} = 24+k, data 1..4.
        for (int k = 0; k < 4; k++) begin
            fbw_wren = 1'b1; fbw_col_addr = k[1:0]; fbw_data = 24'(k + 1);
            tick();
        end
        fbw_wren = 1'b0;
        fbw_row_addr = 2'd2; fbw_row_store = 1'b1; fbw_row_swap = 1'b1;
        tick();
        fbw_row_store = 1'b0; fbw_row_swap = 1'b0;
        chk("store_rdy_drop", 32'(fbw_row_rdy), 0);
        chk("store_no_we_yet", 32'(mem_we), 0);
        run_copy(24, 1, 1, 1'b0);

        // Row 3 from half 1 (written during previous copy), with a store issued while busy.
        fbw_row_addr = 2'd3; fbw_row_store = 1'b1; fbw_row_swap = 1'b1;
        tick();
        fbw_row_store = 1'b0; fbw_row_swap = 1'b0;
        run_copy(28, 32'hAA0000, 2, 1'b0);
        chk("idle_after_busy_store", 32'(fbw_row_rdy), 1);

        // Frame swap with the copy idle.
        frame_swap = 1'b1;
        #1;
        chk("frame_rdy_swap_cycle", 32'(frame_rdy), 0);
        tick();
        frame_swap = 1'b0;
        chk("bank_before_flip", 32'(disp_bank), 0);
        chk("frame_rdy_pend", 32'(frame_rdy), 0);
`ifdef FB_ROW_WRITER_VSYNC_SWAP_EN
        begin
            int low_cnt = 0;
            for (int j = 0; j < 10; j++) begin
                if (!frame_rdy) low_cnt++;
                chk("bank_wait_vsync", 32'(disp_bank), 0);
                disp_vsync = (j == 9);
                tick();
            end
            disp_vsync = 1'b0;
            chk("frame_rdy_low_cycles", 32'(low_cnt), 10);
        end
`else
        disp_vsync = 1'b0;
        tick();
`endif
        chk("bank_after_flip", 32'(disp_bank), 1);
        chk("frame_rdy_after_flip", 32'(frame_rdy), 1);

        // Next store targets bank 0; double frame_swap and an early vsync during the copy.
        fbw_row_addr = 2'd1; fbw_row_store = 1'b1;
        tick();
        fbw_row_store = 1'b0;
        run_copy(4, 1, 3, 1'b1);
`ifdef FB_ROW_WRITER_VSYNC_SWAP_EN
        chk("no_flip_without_vsync", 32'(disp_bank), 1);
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
`endif
        chk("single_flip_bank", 32'(disp_bank), 0);
        for (int j = 0; j < 3; j++) begin
            disp_vsync = 1'b1;
            tick();
            disp_vsync = 1'b0;
            tick();
        end
        chk("single_flip_hold", 32'(disp_bank), 0);
        chk("frame_rdy_settled", 32'(frame_rdy), 1);

        // Asynchronous reset in the middle of a copy.
        fbw_row_addr = 2'd0; fbw_row_store = 1'b1;
        tick();
        fbw_row_store = 1'b0;
        tick();
        tick();
        chk("midcopy_we_active", 32'(mem_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(mem_we), 0);
        chk("async_rst_rdy", 32'(fbw_row_rdy), 1);
        chk("async_rst_addr", 32'(mem_addr), 0);
        chk("async_rst_bank", 32'(disp_bank), 0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_we", 32'(mem_we), 0);
        chk("post_rst_rdy", 32'(fbw_row_rdy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
